quickq_seq_ctrl: RTL and testbench
==================================

Name: quickq_seq_ctrl

Overview:
- Sequencing controller for the QuickQ sorted priority queue.
- Owns the BRAM port, element count and queue state.
- Enqueue: insertion-sort walk, carrying the new value through the array and swapping wherever it is smaller than the stored entry.
- Dequeue: returns index 0, the minimum, then shifts the remaining entries down one slot.
- Sits between the host request interface and the single-port queue BRAM.

Parameters:
DATA_W, 32, element width in bits
DEPTH, 16, maximum number of queue entries
ADDR_W, $clog2(DEPTH), BRAM address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
enq  in  1  enqueue request, sampled only while busy=0
deq  in  1  dequeue request, sampled only while busy=0
data_in  in  DATA_W  value to enqueue, sampled with enq
data_out  out  DATA_W  dequeued minimum, held until the next dequeue
out_valid  out  1  one-cycle pulse when data_out updates
busy  out  1  operation in progress
full  out  1  count==DEPTH
empty  out  1  count==0
count  out  ADDR_W+1  current number of entries
overflow  out  1  one-cycle pulse: enq while full
underflow  out  1  one-cycle pulse: deq while empty
bram_addr  out  ADDR_W  BRAM address
bram_we  out  1  BRAM write enable
bram_wdata  out  DATA_W  BRAM write data
bram_rdata  in  DATA_W  BRAM read data, valid one cycle after bram_addr is presented

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; count=0, empty=1.
  - All other outputs are 0.
  - BRAM contents are treated as garbage.
  - Reset mid-operation abandons the operation; no partial state survives.
- Ordering and priority rules:
  - Ascending order is kept in BRAM[0..count-1].
  - The compare is unsigned and strict (carry < rdata). Equal values therefore keep FIFO order among themselves.
  - In IDLE with both enq and deq high: deq wins if !empty, otherwise enq. The losing request is dropped; the host re-issues it.
- Request acceptance:
  - enq with full=1 pulses overflow and causes no state change.
  - deq with empty=1 pulses underflow and causes no state change.
  - Requests while busy=1 are ignored with no error pulse.
- States: IDLE, ENQ_RD, ENQ_CMP, ENQ_LAST, DEQ_RD0, DEQ_CAP, DEQ_RD, DEQ_WR.
- Enqueue with n=count:
  - IDLE latches carry=data_in and sets i=0. If n=0 it goes to ENQ_LAST, otherwise to ENQ_RD.
  - ENQ_RD: bram_addr=i, then go to ENQ_CMP.
  - ENQ_CMP: if carry<bram_rdata, write carry to address i and set carry=bram_rdata. Then i++. If i==n go to ENQ_LAST, otherwise to ENQ_RD.
  - ENQ_LAST: write carry to address n, count++, go to IDLE.
  - busy is high for exactly 2n+1 cycles.
- Dequeue with n=count:
  - DEQ_RD0 presents address 0.
  - DEQ_CAP: data_out=bram_rdata and out_valid pulses. If n==1, count-- and go to IDLE; otherwise i=1 and go to DEQ_RD.
  - DEQ_RD: bram_addr=i.
  - DEQ_WR: write bram_rdata to address i-1, then i++. If i==n, count-- and go to IDLE; otherwise go to DEQ_RD.
  - busy is high for exactly 2n cycles.
- bram_we is high only in:
  - ENQ_CMP on a swap;
  - ENQ_LAST;
  - DEQ_WR.
- full, empty and count update on the same edge as the final state transition into IDLE.
- All counters are ADDR_W+1 bits wide, so DEPTH is representable and no wrap-around occurs.

Decomposition:
- quickq_pkg gains:
  - qc_state_t, the state enum;
  - LO_ENQ / LO_DEQ reuse for last-operation tagging.
- One combinational sub-module, quickq_cmp_swap:
  - inputs: carry, rdata;
  - outputs: swap, new_carry, wdata.
- This keeps the compare isolated for unit test.

Test Plan:
- Enqueue 30, 10, 20 into an empty queue, then dequeue 3 times:
  - data_out sequence is 10, 20, 30;
  - count returns to 0 and empty=1.
- Enqueue 4 with count=3 holding {5,7,9}:
  - busy for 7 cycles;
  - BRAM becomes {4,5,7,9}.
- Fill to DEPTH=16, then enq 99:
  - full=1, overflow pulses once, count stays 16.
- deq on an empty queue after reset:
  - underflow pulses once, out_valid stays 0, busy stays 0.
- Enqueue 5 and 5 tagged via low bits (0x105, 0x105) with enq and deq asserted together while count=2:
  - deq wins and returns the minimum;
  - the enq is dropped;
  - count=1.
- Assert rst during the 3rd cycle of an enqueue with count=4:
  - next cycle busy=0, count=0, empty=1;
  - a following enq of 42 then deq returns 42.

Source files
------------

// File: rtl/quickq_pkg.sv
// Shared types for the QuickQ sorted priority queue: sequencer state encoding
// and last-operation tags.
package quickq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENQ_RD,
    ENQ_CMP,
    ENQ_LAST,
    DEQ_RD0,
    DEQ_CAP,
    DEQ_RD,
    DEQ_WR
  } qc_state_t;

  typedef enum logic [1:0] {
    LO_NONE,
    LO_ENQ,
    LO_DEQ
  } last_op_t;

endpackage

// File: rtl/quickq_cmp_swap.sv
// Insertion-sort compare step: decides whether the carried value displaces the
// stored entry, and which value continues down the array.
module quickq_cmp_swap #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] carry,
  input  logic [DATA_W-1:0] rdata,
  output logic              swap,
  output logic [DATA_W-1:0] new_carry,
  output logic [DATA_W-1:0] wdata
);

  // Strict unsigned compare so equal keys keep their arrival order.
  assign swap      = carry < rdata;
  assign new_carry = swap ? rdata : carry;
  assign wdata     = carry;

endmodule

// File: rtl/quickq_seq_ctrl.sv
// QuickQ sequencing controller: owns the single-port queue BRAM, the element
// count and the enqueue/dequeue walks over the sorted array.
module quickq_seq_ctrl
  import quickq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq,
  input  logic              deq,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam int            CW  = ADDR_W + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  qc_state_t         state;
  logic [CW-1:0]     i;
  logic [DATA_W-1:0] carry;

  logic              swap;
  logic [DATA_W-1:0] new_carry;
  logic [DATA_W-1:0] swap_wdata;

  quickq_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
    .carry     (carry),
    .rdata     (bram_rdata),
    .swap      (swap),
    .new_carry (new_carry),
    .wdata     (swap_wdata)
  );

  assign busy  = (state != IDLE);
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      carry     <= '0;
      count     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      case (state)
        IDLE: begin
          // Dequeue has priority; a colliding enqueue is dropped for the host to retry.
          if (deq && !empty) begin
            state <= DEQ_RD0;
          end else if (enq) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              carry <= data_in;
              i     <= '0;
              state <= empty ? ENQ_LAST : ENQ_RD;
            end
          end else if (deq) begin
            underflow <= 1'b1;
          end
        end
        ENQ_RD:  state <= ENQ_CMP;
        ENQ_CMP: begin
          carry <= new_carry;
          i     <= i + ONE;
          state <= (i + ONE == count) ? ENQ_LAST : ENQ_RD;
        end
        ENQ_LAST: begin
          count <= count + ONE;
          state <= IDLE;
        end
        DEQ_RD0: state <= DEQ_CAP;
        DEQ_CAP: begin
          data_out  <= bram_rdata;
          out_valid <= 1'b1;
          if (count == ONE) begin
            count <= count - ONE;
            state <= IDLE;
          end else begin
            i     <= ONE;
            state <= DEQ_RD;
          end
        end
        DEQ_RD:  state <= DEQ_WR;
        DEQ_WR: begin
          i <= i + ONE;
          if (i + ONE == count) begin
            count <= count - ONE;
            state <= IDLE;
          end else begin
            state <= DEQ_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The swap write depends on this cycle's read data, so the BRAM port is
  // decoded combinationally from the registered state.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bram_addr  = '0;
    bram_we    = 1'b0;
    bram_wdata = '0;
    case (state)
      ENQ_RD:  bram_addr = ADDR_W'(i);
      ENQ_CMP: begin
        bram_addr  = ADDR_W'(i);
        bram_we    = swap;
        bram_wdata = swap_wdata;
      end
      ENQ_LAST: begin
        bram_addr  = ADDR_W'(count);
        bram_we    = 1'b1;
        bram_wdata = carry;
      end
      DEQ_RD:  bram_addr = ADDR_W'(i);
      DEQ_WR: begin
        bram_addr  = ADDR_W'(i - ONE);
        bram_we    = 1'b1;
        bram_wdata = bram_rdata;
      end
      default: bram_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_quickq_seq_ctrl.sv
// Directed scoreboard bench for quickq_seq_ctrl with a behavioural
// single-port BRAM (one-cycle read latency).
module tb_quickq_seq_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enq = 1'b0;
  logic              deq = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              out_valid, busy, full, empty, overflow, underflow;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata = '0;

  quickq_seq_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enq        (enq),
    .deq        (deq),
    .data_in    (data_in),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  initial for (int k = 0; k < DEPTH; k++) mem[k] = 32'hDEAD_0000 + k;

  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_ovf = 0;
  int n_udf = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a dequeued value.
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow)  n_ovf++;
      if (underflow) n_udf++;
      if (out_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got 0x%0h expected nothing", data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("data_out", data_out, mon_exp);
        end
      end
    end
  end

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: got busy after %0d cycles expected idle", cyc);
    end
  endtask

  task automatic do_op(input logic e, input logic d, input logic [DATA_W-1:0] v, output int cyc);
    @(negedge clk);
    enq = e; deq = d; data_in = v;
    @(negedge clk);
    enq = 1'b0; deq = 1'b0;
    wait_idle(cyc);
  endtask

  task automatic enq_v(input logic [DATA_W-1:0] v, input int exp_cyc);
    int c;
    do_op(1'b1, 1'b0, v, c);
    check("enq_busy_cycles", c, exp_cyc);
  endtask

  task automatic deq_v(input logic [DATA_W-1:0] exp_val, input int exp_cyc);
    int c;
    exp_q.push_back(exp_val);
    do_op(1'b0, 1'b1, '0, c);
    check("deq_busy_cycles", c, exp_cyc);
  endtask

  initial begin
    int c;
    int ovf0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_data_out", data_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // Dequeue on empty queue
    do_op(1'b0, 1'b1, '0, c);
    check("udf_busy_cycles", c, 0);
    @(negedge clk); #1;
    check("udf_pulses", n_udf, 1);
    check("udf_no_valid", n_valid, 0);
    check("udf_busy", busy, 0);

    // 30,10,20 in; 10,20,30 out
    enq_v(30, 1);
    enq_v(10, 3);
    enq_v(20, 5);
    check("three_count", count, 3);
    deq_v(10, 6);
    deq_v(20, 4);
    deq_v(30, 2);
    #1;
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    check("drain_valids", n_valid, 3);

    // Insert 4 at the head of {5,7,9}
    enq_v(5, 1);
    enq_v(7, 3);
    enq_v(9, 5);
    enq_v(4, 7);
    check("ins_mem0", mem[0], 4);
    check("ins_mem1", mem[1], 5);
    check("ins_mem2", mem[2], 7);
    check("ins_mem3", mem[3], 9);
    check("ins_count", count, 4);
    deq_v(4, 8);
    deq_v(5, 6);
    deq_v(7, 4);
    deq_v(9, 2);

    // Fill with descending values, then overflow
    for (int k = 0; k < DEPTH; k++) enq_v(32'(100 - k), 2 * k + 1);
    check("fill_full", full, 1);
    check("fill_count", count, DEPTH);
    ovf0 = n_ovf;
    do_op(1'b1, 1'b0, 99, c);
    check("ovf_busy_cycles", c, 0);
    @(negedge clk); #1;
    check("ovf_pulses", n_ovf - ovf0, 1);
    check("ovf_count", count, DEPTH);
    check("ovf_full", full, 1);
    for (int k = 0; k < DEPTH; k++) deq_v(32'(85 + k), 2 * (DEPTH - k));
    #1;
    check("fill_drain_empty", empty, 1);

    // Equal keys, then simultaneous enq+deq: deq wins
    enq_v(32'h105, 1);
    enq_v(32'h105, 3);
    exp_q.push_back(32'h105);
    do_op(1'b1, 1'b1, 32'h200, c);
    check("both_busy_cycles", c, 4);
    check("both_count", count, 1);
    deq_v(32'h105, 2);

    // Reset in the third busy cycle of an enqueue with count=4
    enq_v(1, 1);
    enq_v(2, 3);
    enq_v(3, 5);
    enq_v(4, 7);
    @(negedge clk);
    enq = 1'b1; data_in = 50;
    @(negedge clk);
    enq = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_count", count, 0);
    @(negedge clk);
    check("midrst_next_busy", busy, 0);
    check("midrst_next_count", count, 0);
    check("midrst_next_empty", empty, 1);
    rst = 1'b0;
    enq_v(42, 1);
    deq_v(42, 2);
    #1;
    check("final_data_out", data_out, 42);
    check("final_count", count, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
